// File: rtl/spi_reg_slave_pkg.sv
// ============================================================================
//  Module   : spi_reg_pkg
//  Brief    : Frame geometry, register map and FSM states for spi_reg_slave.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 5;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

    // Counter parks one past a full frame so over-long frames stay detectable.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_reg_slave_sync_ff.sv
// ============================================================================
//  Module   : sync_ff
//  Brief    : Multi-flop synchroniser for one asynchronous pad, with reset value.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_reg_slave.sv
// ============================================================================
//  Module   : spi_reg_slave
//  Brief    : Mode-0 SPI target writing 16-bit frames into five control
//             registers. Define SPI_READBACK_EN to enable register reads on cipo.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              cipo,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

    logic sclk_s, copi_s, ncs_s;
    logic sclk_h_q, ncs_h_q;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi), .q_o(copi_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs), .q_o(ncs_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_h_q <= 1'b0;
            ncs_h_q  <= 1'b1;
        end else begin
            sclk_h_q <= sclk_s;
            ncs_h_q  <= ncs_s;
        end
    end

    logic w_sclk_rise, w_ncs_fall, w_ncs_rise;
    assign w_sclk_rise = sclk_s & ~sclk_h_q;
    assign w_ncs_fall  = ~ncs_s & ncs_h_q;
    assign w_ncs_rise  = ncs_s & ~ncs_h_q;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic                    frame_err_q;
    logic [DATA_W-1:0]       regs_q [0:4];

    logic [ADDR_W-1:0] w_addr;
    logic              w_addr_ok;
    logic              w_full;
    assign w_addr    = shift_q[14:8];
    assign w_addr_ok = (w_addr < NUM_REGS_A);
    assign w_full    = (cnt_q == CNT_FULL);

`ifdef SPI_READBACK_EN
    logic              w_sclk_fall;
    logic              cipo_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] w_rd_byte;
    assign w_sclk_fall = ~sclk_s & sclk_h_q;

    // Header byte sits in shift_q[7:0] exactly when the 8th rise has been counted.
    always_comb begin
        w_rd_byte = '0;
        if (!shift_q[7] && (shift_q[6:0] < NUM_REGS_A)) begin
            case (shift_q[6:0])
                ADDR_EN_OUT_LO: w_rd_byte = regs_q[0];
                ADDR_EN_OUT_HI: w_rd_byte = regs_q[1];
                ADDR_EN_PWM_LO: w_rd_byte = regs_q[2];
                ADDR_EN_PWM_HI: w_rd_byte = regs_q[3];
                ADDR_DUTY:      w_rd_byte = regs_q[4];
                default:        w_rd_byte = '0;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 5; i++) regs_q[i] <= '0;
`ifdef SPI_READBACK_EN
            cipo_q      <= 1'b0;
            rd_q        <= '0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef SPI_READBACK_EN
                    cipo_q <= 1'b0;
`endif
                    if (w_ncs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end
                end
                SHIFT: begin
                    if (w_ncs_rise) begin
                        state_q <= COMMIT;
                    end else if (w_sclk_rise) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
                        cnt_q   <= (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 1'b1;
                    end
`ifdef SPI_READBACK_EN
                    else if (w_sclk_fall && cnt_q == 5'd8) begin
                        cipo_q <= w_rd_byte[7];
                        rd_q   <= {w_rd_byte[6:0], 1'b0};
                    end else if (w_sclk_fall && cnt_q > 5'd8 && cnt_q < CNT_FULL) begin
                        cipo_q <= rd_q[7];
                        rd_q   <= {rd_q[6:0], 1'b0};
                    end
`endif
                end
                COMMIT: begin
                    if (w_full && shift_q[15] && w_addr_ok) begin
                        case (w_addr)
                            ADDR_EN_OUT_LO: regs_q[0] <= shift_q[7:0];
                            ADDR_EN_OUT_HI: regs_q[1] <= shift_q[7:0];
                            ADDR_EN_PWM_LO: regs_q[2] <= shift_q[7:0];
                            ADDR_EN_PWM_HI: regs_q[3] <= shift_q[7:0];
                            ADDR_DUTY:      regs_q[4] <= shift_q[7:0];
                            default:        ;
                        endcase
                    end
`ifdef SPI_READBACK_EN
                    else if (w_full && !shift_q[15] && w_addr_ok) begin
                        frame_err_q <= 1'b0;
                    end
`endif
                    else begin
                        frame_err_q <= 1'b1;
                    end
`ifdef SPI_READBACK_EN
                    cipo_q <= 1'b0;
`endif
                    // A new frame may open while the previous one is committing.
                    if (w_ncs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign frame_err       = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
// ============================================================================
//  Module   : tb_spi_reg_slave
//  Brief    : Scoreboard bench for spi_reg_slave: directed SPI frames, expected
//             register snapshots / error pulses queued and checked by a monitor.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_reg_slave;

    localparam int SCK_HALF = 500;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic       cipo;
    logic [7:0] r0, r1, r2, r3, r4;
    logic       frame_err;

    spi_reg_slave #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .cipo           (cipo),
        .en_reg_out_7_0 (r0),
        .en_reg_out_15_8(r1),
        .en_reg_pwm_7_0 (r2),
        .en_reg_pwm_15_8(r3),
        .pwm_duty_cycle (r4),
        .frame_err      (frame_err)
    );

    always #50 clk = ~clk;

    typedef struct packed {
        logic [39:0] snap;
        logic        err;
    } ev_t;

    ev_t         q[$];
    ev_t         ev;
    logic [7:0]  e [5];
    logic [39:0] prev;
    logic [15:0] rx;
    logic [7:0]  v5 [5];
    logic [7:0]  rb;
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    bit          cipo_hi = 1'b0;

    function automatic logic [39:0] exp_snap();
        return {e[4], e[3], e[2], e[1], e[0]};
    endfunction

    task automatic push(input logic err);
        ev_t x;
        x.snap = exp_snap();
        x.err  = err;
        q.push_back(x);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 6 && q.size() != 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected events outstanding, expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic bit_cycle(input logic b);
        copi = b;
        #SCK_HALF;
        sclk = 1'b1;
        #SCK_HALF;
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] f, input int nbits, output logic [15:0] rxo);
        rxo = '0;
        ncs = 1'b0;
        #SCK_HALF;
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? f[15-i] : 1'b0;
            #SCK_HALF;
            if (i < 16) rxo[15-i] = cipo;
            sclk = 1'b1;
            #SCK_HALF;
            sclk = 1'b0;
        end
        #SCK_HALF;
        ncs  = 1'b1;
        copi = 1'b0;
    endtask

    // Monitor: every register change or error pulse must match the next queued event.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (({r4, r3, r2, r1, r0} != prev) || frame_err) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event: regs=%h err=%b, expected no activity",
                                 {r4, r3, r2, r1, r0}, frame_err);
                    end else begin
                        ev = q.pop_front();
                        if ({r4, r3, r2, r1, r0} !== ev.snap || frame_err !== ev.err) begin
                            bad++;
                            $display("FAIL event: regs=%h err=%b, expected regs=%h err=%b",
                                     {r4, r3, r2, r1, r0}, frame_err, ev.snap, ev.err);
                        end
                    end
                end
                prev = {r4, r3, r2, r1, r0};
                if (cipo !== 1'b0) cipo_hi = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) e[i] = 8'h00;
        v5[0] = 8'h11; v5[1] = 8'h22; v5[2] = 8'h33; v5[3] = 8'h44; v5[4] = 8'h55;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk8("rst_out_lo", r0, 8'h00);
        chk8("rst_out_hi", r1, 8'h00);
        chk8("rst_pwm_lo", r2, 8'h00);
        chk8("rst_pwm_hi", r3, 8'h00);
        chk8("rst_duty",   r4, 8'h00);
        chk8("rst_ferr",   {7'd0, frame_err}, 8'h00);
        chk8("rst_cipo",   {7'd0, cipo}, 8'h00);
        prev   = {r4, r3, r2, r1, r0};
        mon_en = 1'b1;

        // basic write
        e[0] = 8'hF0; push(1'b0);
        spi_frame(16'h80F0, 16, rx); wait_drain("t1_write_out_lo");

        // duty write, then out-of-range address
        e[4] = 8'h80; push(1'b0);
        spi_frame(16'h8480, 16, rx); wait_drain("t2_write_duty");
        push(1'b1);
        spi_frame(16'h90FF, 16, rx); wait_drain("t2_bad_addr");

        // short and long frames
        push(1'b1);
        spi_frame(16'h8177, 12, rx); wait_drain("t3_short_frame");
        push(1'b1);
        spi_frame(16'h8177, 17, rx); wait_drain("t3_long_frame");

        // reset in the middle of a frame
        ncs = 1'b0;
        #SCK_HALF;
        for (int i = 0; i < 9; i++) bit_cycle(rx[0] ^ rx[0] ^ ((16'h82AA >> (15 - i)) & 1'b1));
        #200;
        for (int i = 0; i < 5; i++) e[i] = 8'h00;
        push(1'b0);
        push(1'b1);
        rst_n = 1'b0;
        #200;
        rst_n = 1'b1;
        #100;
        for (int i = 9; i < 16; i++) bit_cycle((16'h82AA >> (15 - i)) & 1'b1);
        #SCK_HALF;
        ncs  = 1'b1;
        copi = 1'b0;
        wait_drain("t4_reset_midframe");
        e[2] = 8'hAA; push(1'b0);
        spi_frame(16'h82AA, 16, rx); wait_drain("t4_write_after_reset");

        // back-to-back writes, 2 clk ncs-high gap
        for (int k = 0; k < 5; k++) begin
            e[k] = v5[k];
            push(1'b0);
            spi_frame({1'b1, 7'(k), v5[k]}, 16, rx);
            #200;
        end
        wait_drain("t5_back_to_back");

        // readback
        e[3] = 8'h5A; push(1'b0);
        spi_frame(16'h835A, 16, rx); wait_drain("t6_write_pwm_hi");
`ifdef SPI_READBACK_EN
        spi_frame(16'h0300, 16, rx);
        rb = 8'h5A;
        for (int j = 7; j >= 0; j--) begin
            total++;
            if (rx[j] !== rb[j]) begin
                bad++;
                $display("FAIL t6_read_bit%0d: got %b, expected %b", j, rx[j], rb[j]);
            end
        end
        wait_drain("t6_read_no_event");
`else
        rb = 8'h00;
        push(1'b1);
        spi_frame(16'h0300, 16, rx); wait_drain("t6_read_discard");
        chk8("t6_read_cipo_data", rx[7:0], rb);
        total++;
        if (cipo_hi) begin
            bad++;
            $display("FAIL cipo_idle: got 1 at some point, expected constant 0");
        end
`endif
        repeat (10) @(negedge clk);
        chk8("final_out_lo", r0, 8'h11);
        chk8("final_pwm_hi", r3, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
